axis_video_framer: RTL and testbench
====================================

// Module: axis_video_framer
// PURPOSE
//  Upstream neighbour of the AES-CTR encryption stage. Takes a raw 24-bit RGB pixel AXI-Stream,
//  counts pixels per line and lines per frame, and emits AXI4-Stream video with tuser and tlast.
//  tuser marks the start of frame (SOF); tlast marks the end of line (EOL).
//  Gives the encryptor frame-aligned input, so its counter/nonce restarts on every SOF.
// PARAMETERS
//  H_RESOLUTION     1920  active pixels per line
//  V_RESOLUTION     1080  active lines per frame
//  C_AXIS_TDATA_WIDTH 24  pixel width (RGB888); tkeep width = C_AXIS_TDATA_WIDTH/8
//  USE_S_TLAST      0     1: upstream s00_axis_tlast is checked and used to resync lines
// PORTS
//  axis_aclk        in   1    single clock for both streams
//  axis_reset       in   1    synchronous, active-high reset
//  enable           in   1    run request; acted on only at a frame boundary
//  s00_axis_tdata   in   24   input pixel
//  s00_axis_tvalid  in   1    input valid
//  s00_axis_tlast   in   1    upstream EOL; ignored when USE_S_TLAST=0
//  s00_axis_tready  out  1    input ready (registered)
//  m00_axis_tdata   out  24   output pixel
//  m00_axis_tvalid  out  1    output valid
//  m00_axis_tready  in   1    downstream ready
//  m00_axis_tlast   out  1    EOL: asserted on the last pixel of each line
//  m00_axis_tuser   out  1    SOF: asserted on the first pixel of each frame
//  m00_axis_tkeep   out  3    all-ones whenever m00_axis_tvalid=1
//  frame_done       out  1    1-cycle pulse when the last pixel of a frame is accepted downstream
//  err_early_eol    out  1    sticky: s tlast arrived before pixel H-1
//  err_late_eol     out  1    sticky: pixel H-1 arrived without s tlast
// BEHAVIOUR
//  Reset values (axis_reset=1, sampled on the rising axis_aclk edge):
//   - all outputs 0 except m00_axis_tkeep=3'b111
//   - h_cnt=0, v_cnt=0, state=IDLE, skid buffer empty
//  FSM:
//   - IDLE: s00_axis_tready=0. Goes to RUN when enable=1.
//   - RUN: passes pixels. Returns to IDLE after the last pixel of a frame (h=H-1, v=V-1) is
//     accepted on the input, if enable=0 at that point. Frames are never truncated by enable.
//  Data path:
//   - 2-entry skid buffer; output registered.
//   - Latency: 1 cycle from input handshake to m00_axis_tvalid. Full throughput (1 pixel/clk).
//   - s00_axis_tready = RUN and skid buffer not full; it is registered.
//  Output rules:
//   - m00 data/tlast/tuser stay stable while m00_axis_tvalid=1 and m00_axis_tready=0.
//   - AXIS rule: tvalid never depends on tready.
//  Counters (advance on the input handshake, s00_axis_tvalid & s00_axis_tready):
//   - Tags attached to the pixel: tuser = (h==0 && v==0); tlast = (h==H-1).
//   - h wraps H-1 -> 0 and increments v; v wraps V-1 -> 0.
//   - Widths: h is $clog2(H_RESOLUTION) bits, v is $clog2(V_RESOLUTION) bits; no overflow at 1920/1080.
//  Line resync (USE_S_TLAST=1):
//   - s tlast with h<H-1: tag tlast, set err_early_eol, h->0, v++ (line ends short).
//   - h==H-1 without s tlast: tag tlast anyway, set err_late_eol, normal wrap.
//   - Sticky error flags clear only on axis_reset.
//  Simultaneous / boundary events:
//   - Input handshake on the same cycle as an output stall: pixel goes into the skid buffer; no loss.
//   - enable falling mid-frame: the frame completes.
//   - axis_reset mid-frame: drop all buffered pixels. The next accepted pixel is tagged SOF.
// STRUCTURE
//  Shared package video_axis_pkg:
//   - FSM state typedef {IDLE, RUN}
//   - constants DEF_H_RES=1920, DEF_V_RES=1080, RGB_W=24
//   - counter width functions, reused by the AES_CTR frame logic
//  One sub-module: axis_skid_buffer (width-parameterized 2-entry register slice, tdata+tlast+tuser).
// TESTING  (bench runs H=4, V=3 unless noted)
//  1. enable=1, continuous valid, tready=1, pixels 0..11:
//     -> tuser on pixel 0 only; tlast on pixels 3,7,11; frame_done 1 cycle after pixel 11 accepted.
//  2. Frame as in 1, tready toggling 1/0 every cycle:
//     -> output order 0..11 intact, no duplicates, data stable while stalled.
//  3. USE_S_TLAST=1, s tlast on pixel 2 of line 0:
//     -> m tlast on pixel 2, err_early_eol=1, next pixel starts line 1 (h=0).
//  4. USE_S_TLAST=1, no s tlast on pixel 3:
//     -> m tlast on pixel 3, err_late_eol=1.
//  5. axis_reset for 1 cycle after pixel 5 (mid-frame):
//     -> outputs 0, next accepted pixel has tuser=1.
//  6. Defaults 1920x1080, feed 24'h00fff0 for 2 frames:
//     -> tlast every 1920 pixels; tuser at pixels 0 and 2073600; enable=0 mid-frame 2 still ends on pixel 4147199.

Source files
------------

// File: rtl/video_axis_pkg.sv
// Shared definitions for the video AXI-Stream framer and the AES-CTR frame logic.
package video_axis_pkg;

  localparam int DEF_H_RES = 1920;
  localparam int DEF_V_RES = 1080;
  localparam int RGB_W     = 24;

  // Framer FSM states.
  typedef logic [0:0] framer_state_t;
  localparam framer_state_t ST_IDLE = 1'b0;
  localparam framer_state_t ST_RUN  = 1'b1;

  // Bits needed to count 0..n-1; never below one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int h_cnt_width(input int h_res);
    return cnt_width(h_res);
  endfunction

  function automatic int v_cnt_width(input int v_res);
    return cnt_width(v_res);
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-Stream register slice: an output register plus one skid
// register, with a registered s_tready so the ready path is fully cut.
module axis_skid_buffer #(
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_enable,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tvalid,
  input  logic              s_tlast,
  input  logic              s_tuser,
  output logic              s_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  output logic              m_tlast,
  output logic              m_tuser,
  input  logic              m_tready
);

  localparam int PW = DATA_W + 2;

  logic [PW-1:0] out_q;
  logic [PW-1:0] skid_q;
  logic [PW-1:0] s_payload;
  logic          out_valid_q;
  logic          skid_valid_q;
  logic          ready_q;
  logic          s_hs;
  logic          out_free;
  logic          skid_valid_d;

  assign s_payload = {s_tuser, s_tlast, s_tdata};
  assign s_hs      = s_tvalid & ready_q;
  assign out_free  = ~out_valid_q | m_tready;

  // Next occupancy of the skid register.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (latch).
    skid_valid_d = skid_valid_q;
    if (out_free)
      skid_valid_d = 1'b0;
    else if (s_hs)
      skid_valid_d = 1'b1;
  end

  // Move pixels input -> output register, or park them in the skid register on a stall.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      // NOTE: data registers are reset too, because the stream outputs must read zero in reset.
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      skid_valid_q <= skid_valid_d;
      // Ready is high only when the skid register is guaranteed free next cycle.
      ready_q      <= s_enable & ~skid_valid_d;
      if (out_free) begin
        if (skid_valid_q) begin
          out_q       <= skid_q;
          out_valid_q <= 1'b1;
        end else if (s_hs) begin
          out_q       <= s_payload;
          out_valid_q <= 1'b1;
        end else begin
          out_valid_q <= 1'b0;
        end
      end
      if (!out_free && s_hs)
        skid_q <= s_payload;
    end
  end

  assign s_tready = ready_q;
  assign m_tvalid = out_valid_q;
  assign m_tdata  = out_q[DATA_W-1:0];
  assign m_tlast  = out_q[DATA_W];
  assign m_tuser  = out_q[DATA_W+1];

endmodule

// File: rtl/axis_video_framer.sv
// Frames a raw RGB pixel stream into AXI4-Stream video: tuser on the first
// pixel of each frame, tlast on the last pixel of each line.
module axis_video_framer
  import video_axis_pkg::*;
#(
  parameter int H_RESOLUTION       = DEF_H_RES,
  parameter int V_RESOLUTION       = DEF_V_RES,
  parameter int C_AXIS_TDATA_WIDTH = RGB_W,
  parameter int USE_S_TLAST        = 0
) (
  input  logic                            axis_aclk,
  input  logic                            axis_reset,
  input  logic                            enable,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
  input  logic                            s00_axis_tvalid,
  input  logic                            s00_axis_tlast,
  output logic                            s00_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
  output logic                            m00_axis_tvalid,
  input  logic                            m00_axis_tready,
  output logic                            m00_axis_tlast,
  output logic                            m00_axis_tuser,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tkeep,
  output logic                            frame_done,
  output logic                            err_early_eol,
  output logic                            err_late_eol
);

  localparam int H_W = h_cnt_width(H_RESOLUTION);
  localparam int V_W = v_cnt_width(V_RESOLUTION);
  localparam int D_W = C_AXIS_TDATA_WIDTH;
  localparam logic [H_W-1:0] H_LAST = H_W'(H_RESOLUTION - 1);
  localparam logic [V_W-1:0] V_LAST = V_W'(V_RESOLUTION - 1);

  framer_state_t  state_q;
  framer_state_t  state_d;
  logic [H_W-1:0] h_q;
  logic [V_W-1:0] v_q;
  logic           s_hs;
  logic           s_eol;
  logic           at_h_last;
  logic           line_end;
  logic           frame_end;
  logic           tag_user;
  logic           early_q;
  logic           late_q;
  logic           done_q;
  logic [D_W:0]   buf_tdata;
  logic           buf_eof;

  assign s_hs      = s00_axis_tvalid & s00_axis_tready;
  assign s_eol     = (USE_S_TLAST != 0) && s00_axis_tlast;
  assign at_h_last = (h_q == H_LAST);
  // An upstream EOL may end a line short; the last column always ends it.
  assign line_end  = at_h_last | s_eol;
  assign frame_end = line_end & (v_q == V_LAST);
  assign tag_user  = (h_q == '0) && (v_q == '0);

  // Run/stop decision: starts on enable, stops only after a whole frame has been accepted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (enable) state_d = ST_RUN;
      ST_RUN:  if (s_hs && frame_end && !enable) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge axis_aclk) begin
    if (axis_reset)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  // Pixel/line counters, advanced on each accepted input pixel.
  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      h_q <= '0;
      v_q <= '0;
    end else if (s_hs) begin
      if (line_end) begin
        h_q <= '0;
        v_q <= (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_q <= h_q + 1'b1;
      end
    end
  end

  // Sticky line-length errors against the upstream EOL marker.
  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      early_q <= 1'b0;
      late_q  <= 1'b0;
    end else if (s_hs && (USE_S_TLAST != 0)) begin
      if (s00_axis_tlast && !at_h_last)
        early_q <= 1'b1;
      if (at_h_last && !s00_axis_tlast)
        late_q <= 1'b1;
    end
  end

  // The end-of-frame tag rides alongside the pixel so completion is seen at the output.
  axis_skid_buffer #(
    .DATA_W (D_W + 1)
  ) u_skid (
    .clk      (axis_aclk),
    .rst      (axis_reset),
    .s_enable (state_d == ST_RUN),
    .s_tdata  ({frame_end, s00_axis_tdata}),
    .s_tvalid (s00_axis_tvalid),
    .s_tlast  (line_end),
    .s_tuser  (tag_user),
    .s_tready (s00_axis_tready),
    .m_tdata  (buf_tdata),
    .m_tvalid (m00_axis_tvalid),
    .m_tlast  (m00_axis_tlast),
    .m_tuser  (m00_axis_tuser),
    .m_tready (m00_axis_tready)
  );

  assign m00_axis_tdata = buf_tdata[D_W-1:0];
  assign buf_eof        = buf_tdata[D_W];

  // One-cycle pulse after the frame's last pixel leaves downstream.
  always_ff @(posedge axis_aclk) begin
    if (axis_reset)
      done_q <= 1'b0;
    else
      done_q <= m00_axis_tvalid & m00_axis_tready & buf_eof;
  end

  assign frame_done     = done_q;
  assign err_early_eol  = early_q;
  assign err_late_eol   = late_q;
  assign m00_axis_tkeep = '1;

endmodule

// File: tb/tb_axis_video_framer.sv
// Directed bench: dut 0 = 4x3 without upstream tlast, dut 1 = 4x3 with upstream
// tlast, dut 2 = 1920x1080 defaults. All share the input stimulus.
module tb_axis_video_framer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic [23:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tlast = 1'b0;
  logic        m_ready = 1'b1;

  logic        o_tready [3];
  logic [23:0] o_data   [3];
  logic        o_valid  [3];
  logic        o_last   [3];
  logic        o_user   [3];
  logic [2:0]  o_keep   [3];
  logic        o_done   [3];
  logic        o_early  [3];
  logic        o_late   [3];

  int checks = 0;
  int errors = 0;
  int sel = 0;

  logic [23:0] pix_q [$];
  bit          eol_q [$];
  logic [23:0] out_data [$];
  bit          out_last [$];
  bit          out_user [$];
  int          done_at  [$];
  int          stall_err;
  bit          timed_out;

  always #5 clk = ~clk;

  axis_video_framer #(.H_RESOLUTION(4), .V_RESOLUTION(3), .USE_S_TLAST(0)) dut_a (
    .axis_aclk(clk), .axis_reset(rst), .enable(enable),
    .s00_axis_tdata(s_tdata), .s00_axis_tvalid(s_tvalid), .s00_axis_tlast(s_tlast),
    .s00_axis_tready(o_tready[0]), .m00_axis_tdata(o_data[0]), .m00_axis_tvalid(o_valid[0]),
    .m00_axis_tready(m_ready), .m00_axis_tlast(o_last[0]), .m00_axis_tuser(o_user[0]),
    .m00_axis_tkeep(o_keep[0]), .frame_done(o_done[0]),
    .err_early_eol(o_early[0]), .err_late_eol(o_late[0]));

  axis_video_framer #(.H_RESOLUTION(4), .V_RESOLUTION(3), .USE_S_TLAST(1)) dut_b (
    .axis_aclk(clk), .axis_reset(rst), .enable(enable),
    .s00_axis_tdata(s_tdata), .s00_axis_tvalid(s_tvalid), .s00_axis_tlast(s_tlast),
    .s00_axis_tready(o_tready[1]), .m00_axis_tdata(o_data[1]), .m00_axis_tvalid(o_valid[1]),
    .m00_axis_tready(m_ready), .m00_axis_tlast(o_last[1]), .m00_axis_tuser(o_user[1]),
    .m00_axis_tkeep(o_keep[1]), .frame_done(o_done[1]),
    .err_early_eol(o_early[1]), .err_late_eol(o_late[1]));

  axis_video_framer dut_c (
    .axis_aclk(clk), .axis_reset(rst), .enable(enable),
    .s00_axis_tdata(s_tdata), .s00_axis_tvalid(s_tvalid), .s00_axis_tlast(s_tlast),
    .s00_axis_tready(o_tready[2]), .m00_axis_tdata(o_data[2]), .m00_axis_tvalid(o_valid[2]),
    .m00_axis_tready(m_ready), .m00_axis_tlast(o_last[2]), .m00_axis_tuser(o_user[2]),
    .m00_axis_tkeep(o_keep[2]), .frame_done(o_done[2]),
    .err_early_eol(o_early[2]), .err_late_eol(o_late[2]));

  task automatic do_reset();
    enable   = 1'b0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    m_ready  = 1'b1;
    rst      = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic load_pixels(input int n, input logic [23:0] base, input int step);
    pix_q.delete();
    eol_q.delete();
    for (int i = 0; i < n; i++) begin
      pix_q.push_back(base + 24'(i * step));
      eol_q.push_back(1'b0);
    end
  endtask

  // Feeds pix_q into the shared inputs and records handshakes of the selected dut.
  // ready_mode 0: m_ready held high; 1: m_ready toggles every cycle.
  task automatic run_stream(input int ready_mode, input int drop_en_at, input int budget);
    int idx = 0;
    int cyc = 0;
    int drain = 0;
    bit hs;
    bit was_stall = 1'b0;
    logic [25:0] held = '0;
    out_data.delete();
    out_last.delete();
    out_user.delete();
    done_at.delete();
    stall_err = 0;
    m_ready  = 1'b1;
    s_tvalid = (pix_q.size() > 0);
    if (pix_q.size() > 0) begin
      s_tdata = pix_q[0];
      s_tlast = eol_q[0];
    end
    while (drain < 4 && cyc < budget) begin
      @(negedge clk);
      hs = s_tvalid && o_tready[sel];
      if (o_done[sel]) done_at.push_back(out_data.size());
      if (was_stall && o_valid[sel] && ({o_user[sel], o_last[sel], o_data[sel]} !== held))
        stall_err++;
      was_stall = o_valid[sel] && !m_ready;
      held = {o_user[sel], o_last[sel], o_data[sel]};
      if (o_valid[sel] && m_ready) begin
        out_data.push_back(o_data[sel]);
        out_last.push_back(o_last[sel]);
        out_user.push_back(o_user[sel]);
      end
      @(posedge clk);
      #1;
      cyc++;
      if (hs) idx++;
      if (idx == drop_en_at) enable = 1'b0;
      if (idx < pix_q.size()) begin
        s_tvalid = 1'b1;
        s_tdata  = pix_q[idx];
        s_tlast  = eol_q[idx];
      end else begin
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        drain++;
      end
      m_ready = (ready_mode == 0) ? 1'b1 : ~m_ready;
    end
    timed_out = (cyc >= budget);
  endtask

  task automatic test_reset();
    enable   = 1'b1;
    s_tvalid = 1'b1;
    s_tdata  = 24'hffffff;
    rst      = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({o_valid[d], o_tready[d], o_last[d], o_user[d]} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_ctrl[%0d] got valid/ready/last/user=%b want 0000", d,
                 {o_valid[d], o_tready[d], o_last[d], o_user[d]});
      end
      checks++;
      if (o_data[d] !== 24'h0) begin
        errors++;
        $display("FAIL reset_data[%0d] got %h want 000000", d, o_data[d]);
      end
      checks++;
      if (o_keep[d] !== 3'b111) begin
        errors++;
        $display("FAIL reset_keep[%0d] got %b want 111", d, o_keep[d]);
      end
      checks++;
      if ({o_done[d], o_early[d], o_late[d]} !== 3'b000) begin
        errors++;
        $display("FAIL reset_flags[%0d] got done/early/late=%b want 000", d,
                 {o_done[d], o_early[d], o_late[d]});
      end
    end
    #1 rst = 1'b0;
    s_tvalid = 1'b0;
    enable   = 1'b0;
  endtask

  task automatic test_frame();
    do_reset();
    sel = 0;
    enable = 1'b1;
    load_pixels(13, 24'ha00000, 1);
    run_stream(0, -1, 200);
    checks++;
    if (timed_out) begin errors++; $display("FAIL frame_timeout got timeout want completion"); end
    checks++;
    if (out_data.size() != 13) begin
      errors++;
      $display("FAIL frame_count got %0d want 13", out_data.size());
    end
    for (int i = 0; i < out_data.size() && i < 13; i++) begin
      checks++;
      if (out_data[i] !== 24'ha00000 + 24'(i) || out_user[i] !== (i % 12 == 0) ||
          out_last[i] !== (i % 4 == 3)) begin
        errors++;
        $display("FAIL frame_pixel[%0d] got %h u%b l%b want %h u%b l%b", i, out_data[i],
                 out_user[i], out_last[i], 24'ha00000 + 24'(i), (i % 12 == 0), (i % 4 == 3));
      end
    end
    checks++;
    if (done_at.size() != 1 || done_at[0] != 12) begin
      errors++;
      $display("FAIL frame_done got %0d pulses (first after %0d px) want 1 after 12",
               done_at.size(), (done_at.size() > 0) ? done_at[0] : -1);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    sel = 0;
    enable = 1'b1;
    load_pixels(13, 24'h500000, 3);
    run_stream(1, -1, 400);
    checks++;
    if (timed_out) begin errors++; $display("FAIL bp_timeout got timeout want completion"); end
    checks++;
    if (out_data.size() != 13) begin
      errors++;
      $display("FAIL bp_count got %0d want 13", out_data.size());
    end
    for (int i = 0; i < out_data.size() && i < 13; i++) begin
      checks++;
      if (out_data[i] !== 24'h500000 + 24'(3 * i) || out_user[i] !== (i % 12 == 0) ||
          out_last[i] !== (i % 4 == 3)) begin
        errors++;
        $display("FAIL bp_pixel[%0d] got %h u%b l%b want %h u%b l%b", i, out_data[i],
                 out_user[i], out_last[i], 24'h500000 + 24'(3 * i), (i % 12 == 0), (i % 4 == 3));
      end
    end
    checks++;
    if (stall_err != 0) begin
      errors++;
      $display("FAIL bp_stable got %0d changes while stalled want 0", stall_err);
    end
    checks++;
    if (done_at.size() != 1 || done_at[0] != 12) begin
      errors++;
      $display("FAIL bp_done got %0d pulses want 1 after 12", done_at.size());
    end
  endtask

  task automatic test_early_eol();
    do_reset();
    sel = 1;
    enable = 1'b1;
    load_pixels(7, 24'hd00000, 1);
    eol_q[2] = 1'b1;
    eol_q[6] = 1'b1;
    run_stream(0, -1, 200);
    checks++;
    if (timed_out || out_data.size() != 7) begin
      errors++;
      $display("FAIL early_count got %0d (timeout=%0b) want 7", out_data.size(), timed_out);
    end
    for (int i = 0; i < out_data.size() && i < 7; i++) begin
      checks++;
      if (out_last[i] !== (i == 2 || i == 6) || out_user[i] !== (i == 0)) begin
        errors++;
        $display("FAIL early_tags[%0d] got u%b l%b want u%b l%b", i, out_user[i], out_last[i],
                 (i == 0), (i == 2 || i == 6));
      end
    end
    checks++;
    if ({o_early[1], o_late[1]} !== 2'b10) begin
      errors++;
      $display("FAIL early_flags got early/late=%b want 10", {o_early[1], o_late[1]});
    end
  endtask

  task automatic test_late_eol();
    do_reset();
    sel = 1;
    enable = 1'b1;
    load_pixels(4, 24'he00000, 1);
    run_stream(0, -1, 200);
    checks++;
    if (timed_out || out_data.size() != 4) begin
      errors++;
      $display("FAIL late_count got %0d (timeout=%0b) want 4", out_data.size(), timed_out);
    end
    checks++;
    if (out_data.size() == 4 && {out_last[0], out_last[1], out_last[2], out_last[3]} !== 4'b0001) begin
      errors++;
      $display("FAIL late_tlast got %b want 0001",
               {out_last[0], out_last[1], out_last[2], out_last[3]});
    end
    checks++;
    if ({o_early[1], o_late[1]} !== 2'b01) begin
      errors++;
      $display("FAIL late_flags got early/late=%b want 01", {o_early[1], o_late[1]});
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    sel = 0;
    enable = 1'b1;
    load_pixels(6, 24'hb00000, 1);
    run_stream(0, -1, 200);
    checks++;
    if (timed_out) begin errors++; $display("FAIL midrst_timeout got timeout want completion"); end
    // Park pixels in the buffer behind a stalled output.
    m_ready  = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = 24'hb00006;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++;
    if (o_valid[0] !== 1'b1) begin
      errors++;
      $display("FAIL midrst_buffered got valid=%b want 1", o_valid[0]);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    s_tvalid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({o_valid[0], o_tready[0], o_last[0], o_user[0], o_done[0]} !== 5'b00000 ||
        o_data[0] !== 24'h0) begin
      errors++;
      $display("FAIL midrst_outputs got v/r/l/u/d=%b data=%h want 00000 000000",
               {o_valid[0], o_tready[0], o_last[0], o_user[0], o_done[0]}, o_data[0]);
    end
    load_pixels(4, 24'hc00000, 1);
    run_stream(0, -1, 200);
    checks++;
    if (timed_out || out_data.size() != 4) begin
      errors++;
      $display("FAIL midrst_count got %0d (timeout=%0b) want 4", out_data.size(), timed_out);
    end
    checks++;
    if (out_data.size() > 0 && (out_data[0] !== 24'hc00000 || out_user[0] !== 1'b1)) begin
      errors++;
      $display("FAIL midrst_sof got %h u%b want c00000 u1", out_data[0], out_user[0]);
    end
    checks++;
    if (out_data.size() == 4 && {out_last[0], out_last[1], out_last[2], out_last[3]} !== 4'b0001) begin
      errors++;
      $display("FAIL midrst_tlast got %b want 0001",
               {out_last[0], out_last[1], out_last[2], out_last[3]});
    end
  endtask

  task automatic test_enable_drop();
    int ready_seen = 0;
    do_reset();
    sel = 0;
    enable = 1'b1;
    load_pixels(24, 24'h700000, 1);
    run_stream(0, 14, 300);
    checks++;
    if (timed_out || out_data.size() != 24) begin
      errors++;
      $display("FAIL endrop_count got %0d (timeout=%0b) want 24", out_data.size(), timed_out);
    end
    checks++;
    if (out_data.size() == 24 && (out_last[23] !== 1'b1 || out_user[12] !== 1'b1 ||
        out_data[23] !== 24'h700017)) begin
      errors++;
      $display("FAIL endrop_tags got last23=%b user12=%b data23=%h want 1 1 700017",
               out_last[23], out_user[12], out_data[23]);
    end
    checks++;
    if (done_at.size() != 2 || done_at[0] != 12 || done_at[1] != 24) begin
      errors++;
      $display("FAIL endrop_done got %0d pulses want 2 (after 12 and 24)", done_at.size());
    end
    s_tvalid = 1'b1;
    s_tdata  = 24'h7000ff;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (o_tready[0] || o_valid[0]) ready_seen++;
    end
    s_tvalid = 1'b0;
    checks++;
    if (ready_seen != 0) begin
      errors++;
      $display("FAIL endrop_idle got %0d active cycles after frame want 0", ready_seen);
    end
  endtask

  task automatic test_full_res();
    int bad_last = 0;
    int bad_user = 0;
    int bad_data = 0;
    do_reset();
    sel = 2;
    enable = 1'b1;
    load_pixels(2 * 1920 + 1, 24'h00fff0, 0);
    run_stream(0, -1, 5000);
    checks++;
    if (timed_out || out_data.size() != 3841) begin
      errors++;
      $display("FAIL fullres_count got %0d (timeout=%0b) want 3841", out_data.size(), timed_out);
    end
    for (int i = 0; i < out_data.size(); i++) begin
      if (out_last[i] !== (i % 1920 == 1919)) bad_last++;
      if (out_user[i] !== (i == 0)) bad_user++;
      if (out_data[i] !== 24'h00fff0) bad_data++;
    end
    checks++;
    if (bad_last != 0) begin
      errors++;
      $display("FAIL fullres_tlast got %0d misplaced want 0", bad_last);
    end
    checks++;
    if (bad_user != 0) begin
      errors++;
      $display("FAIL fullres_tuser got %0d misplaced want 0", bad_user);
    end
    checks++;
    if (bad_data != 0) begin
      errors++;
      $display("FAIL fullres_data got %0d wrong pixels want 0", bad_data);
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_backpressure();
    test_early_eol();
    test_late_eol();
    test_mid_reset();
    test_enable_drop();
    test_full_res();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
